multicycle_alu: RTL and testbench

//  Parametrised, handshaked successor of the combinational datapath ALU. Same opcode map, plus
//  a full 2*WIDTH product and separate quotient/remainder. Logic, add/sub, shift and rotate
//  ops complete in 1 cycle. MUL and DIV/REM are iterative, 1 bit per cycle.

---
 rtl/multicycle_alu.sv | 180 ++++++++++++++++++
 tb/tb_multicycle_alu.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/multicycle_alu.sv
// multicycle_alu: handshaked ALU, 1-cycle logic/arith/shift ops, iterative 1-bit/cycle MUL and DIV/REM.
// Define ALU_SIGNED_MULDIV_EN for two's-complement MUL/DIV/REM (magnitude core, sign fix-up on completion).
module multicycle_alu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry_out,
  output logic             overflow,
  output logic             div_by_zero
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [3:0] op_q, op_d;
  logic [SHW-1:0] cnt_q, cnt_d, sh, rs;
  logic [WIDTH-1:0] m_q, m_d, lo_q, lo_d, hi_q, hi_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step, prod;
  logic nlo_q, nlo_d, nhi_q, nhi_d, ov_q, ov_d, c_q, c_d, v_q, v_d, z_q, z_d;
  logic sa, sb, min_neg1, is_dv, dz, ge, r_c, r_v;
  logic [WIDTH-1:0] ma, mb, bb, rot, r_lo, r_hi, quo, rem, dsub;
  logic [WIDTH:0] sum, msum, dt;
`ifdef ALU_SIGNED_MULDIV_EN
  assign sa = A[WIDTH-1];
  assign sb = B[WIDTH-1];
  assign min_neg1 = sa && A[WIDTH-2:0] == '0 && &B;
`else
  assign sa = 1'b0;
  assign sb = 1'b0;
  assign min_neg1 = 1'b0;
`endif
  assign ma = sa ? -A : A;
  assign mb = sb ? -B : B;
  assign is_dv = opcode == 4'd7 || opcode == 4'd8;
  assign dz = is_dv && B == '0;
  assign sh = B[SHW-1:0];
  // ROL by n is ROR by -n, so one double-width shifter serves both rotates
  assign rs = opcode == 4'hC ? -sh : sh;
  assign rot = WIDTH'({A, A} >> rs);
  assign bb = opcode == 4'd5 ? ~B : B;
  assign sum = {1'b0, A} + {1'b0, bb} + (WIDTH+1)'(opcode == 4'd5);
  always_comb begin
    r_lo = '0;
    r_hi = '0;
    r_c = 1'b0;
    r_v = 1'b0;
    case (opcode)
      4'd0: r_lo = A & B;
      4'd1: r_lo = A | B;
      4'd2: r_lo = A ^ B;
      4'd3: r_lo = ~A;
      4'd4, 4'd5: begin
        r_lo = sum[WIDTH-1:0];
        r_c = sum[WIDTH];
        r_v = A[WIDTH-1] == bb[WIDTH-1] && sum[WIDTH-1] != A[WIDTH-1];
      end
      4'd7: begin
        r_lo = '1;
        r_hi = A;
      end
      4'd8: r_lo = A;
      4'd9: r_lo = A << sh;
      4'hA: r_lo = A >> sh;
      4'hB: r_lo = $signed(A) >>> sh;
      4'hC, 4'hD: r_lo = rot;
      default: r_lo = '0;
    endcase
  end
  // acc holds {partial product, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  assign msum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc_q[0]}} & m_q};
  assign dt = acc_q[2*WIDTH-1:WIDTH-1];
  assign ge = dt >= {1'b0, m_q};
  assign dsub = dt[WIDTH-1:0] - m_q;
  assign step = op_q == 4'd6 ? {msum, acc_q[WIDTH-1:1]}
                             : {ge ? dsub : dt[WIDTH-1:0], acc_q[WIDTH-2:0], ge};
  assign prod = nlo_q ? -step : step;
  assign quo = nlo_q ? -step[WIDTH-1:0] : step[WIDTH-1:0];
  assign rem = nhi_q ? -step[2*WIDTH-1:WIDTH] : step[2*WIDTH-1:WIDTH];
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    m_d = m_q;
    acc_d = acc_q;
    nlo_d = nlo_q;
    nhi_d = nhi_q;
    ov_d = ov_q;
    lo_d = lo_q;
    hi_d = hi_q;
    c_d = c_q;
    v_d = v_q;
    z_d = z_q;
    case (state_q)
      IDLE: if (in_valid) begin
        op_d = opcode;
        nlo_d = sa ^ sb;
        nhi_d = sa;
        ov_d = min_neg1 && is_dv;
        m_d = opcode == 4'd6 ? ma : mb;
        acc_d = {{WIDTH{1'b0}}, opcode == 4'd6 ? mb : ma};
        cnt_d = '0;
        if ((opcode == 4'd6 || is_dv) && !dz) state_d = CALC;
        else begin
          state_d = DONE;
          lo_d = r_lo;
          hi_d = r_hi;
          c_d = r_c;
          v_d = r_v;
          z_d = dz;
        end
      end
      CALC: begin
        acc_d = step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SHW'(WIDTH-1)) begin
          state_d = DONE;
          lo_d = op_q == 4'd6 ? prod[WIDTH-1:0] : op_q == 4'd7 ? quo : rem;
          hi_d = op_q == 4'd6 ? prod[2*WIDTH-1:WIDTH] : op_q == 4'd7 ? rem : '0;
          v_d = ov_q;
        end
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        lo_d = '0;
        hi_d = '0;
        c_d = 1'b0;
        v_d = 1'b0;
        z_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      m_q <= '0;
      acc_q <= '0;
      nlo_q <= 1'b0;
      nhi_q <= 1'b0;
      ov_q <= 1'b0;
      lo_q <= '0;
      hi_q <= '0;
      c_q <= 1'b0;
      v_q <= 1'b0;
      z_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      m_q <= m_d;
      acc_q <= acc_d;
      nlo_q <= nlo_d;
      nhi_q <= nhi_d;
      ov_q <= ov_d;
      lo_q <= lo_d;
      hi_q <= hi_d;
      c_q <= c_d;
      v_q <= v_d;
      z_q <= z_d;
    end
  end
  assign in_ready = state_q == IDLE && !clear;
  assign out_valid = state_q == DONE;
  assign result_lo = lo_q;
  assign result_hi = hi_q;
  assign carry_out = c_q;
  assign overflow = v_q;
  assign div_by_zero = z_q;
endmodule

// File: tb/tb_multicycle_alu.sv
// tb_multicycle_alu: directed vectors with a scoreboard queue; a negedge monitor checks each result and its latency.
module tb_multicycle_alu;
  localparam int W = 32;
  logic clock = 1'b0, clear = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0] opcode = '0;
  logic in_ready, out_valid, carry_out, overflow, div_by_zero;
  logic [W-1:0] result_lo, result_hi;
  typedef struct {
    int id;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic c;
    logic v;
    logic z;
    int lat;
  } exp_t;
  exp_t sb_q[$];
  int tests = 0, fails = 0, cyc = 0, acc_cyc = 0;
  logic ov_prev = 1'b0;

  multicycle_alu #(.WIDTH(W)) dut (
    .clock(clock), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .result_lo(result_lo), .result_hi(result_hi), .carry_out(carry_out),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    exp_t e;
    if (in_valid && in_ready) acc_cyc = cyc;
    if (out_valid && !ov_prev) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_output: got lo=%h hi=%h with nothing outstanding", result_lo, result_hi);
      end else begin
        e = sb_q.pop_front();
        if ({result_lo, result_hi, carry_out, overflow, div_by_zero} !== {e.lo, e.hi, e.c, e.v, e.z}
            || cyc - acc_cyc != e.lat) begin
          fails++;
          $display("FAIL vec%0d: got lo=%h hi=%h c=%b v=%b z=%b lat=%0d, want lo=%h hi=%h c=%b v=%b z=%b lat=%0d",
                   e.id, result_lo, result_hi, carry_out, overflow, div_by_zero, cyc - acc_cyc,
                   e.lo, e.hi, e.c, e.v, e.z, e.lat);
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic issue(input int id, input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] lo, input logic [W-1:0] hi,
                       input logic c, input logic v, input logic z, input int lat);
    exp_t e;
    int n;
    e.id = id; e.lo = lo; e.hi = hi; e.c = c; e.v = v; e.z = z; e.lat = lat;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clock); #1; n++; end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL vec%0d_ready_timeout: got in_ready=0 want 1", id);
    end
    sb_q.push_back(e);
    in_valid = 1'b1; A = a; B = b; opcode = op;
    @(posedge clock); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clock); #1; n++; end
    if (!out_valid) begin
      tests++; fails++;
      $display("FAIL vec%0d_done_timeout: got out_valid=0 want 1", id);
    end
    if (out_ready) begin @(posedge clock); #1; end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 chk("reset_outputs", {out_valid, in_ready, result_lo, result_hi, carry_out, overflow, div_by_zero}, '0);
    clear = 1'b0;
    #1 chk("reset_ready", {out_valid, in_ready}, 80'b01);
    @(posedge clock); #1;
    issue(1, 4'd4, 32'hFFFFFFFF, 32'h1, 32'h0, 0, 1, 0, 0, 1);
    issue(2, 4'd4, 32'h7FFFFFFF, 32'h1, 32'h80000000, 0, 0, 1, 0, 1);
    issue(3, 4'd5, 32'd5, 32'd7, 32'hFFFFFFFE, 0, 0, 0, 0, 1);
    issue(4, 4'hC, 32'h80000001, 32'd4, 32'h00000018, 0, 0, 0, 0, 1);
    issue(5, 4'd0, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 0, 1);
    issue(6, 4'd1, 32'h0F000000, 32'h000000F0, 32'h0F0000F0, 0, 0, 0, 0, 1);
    issue(7, 4'd3, 32'h12345678, 32'h0, 32'hEDCBA987, 0, 0, 0, 0, 1);
    issue(8, 4'd9, 32'h1, 32'h1F, 32'h80000000, 0, 0, 0, 0, 1);
    issue(9, 4'd9, 32'h3, 32'd33, 32'h6, 0, 0, 0, 0, 1);
    issue(10, 4'hA, 32'h80000000, 32'd4, 32'h08000000, 0, 0, 0, 0, 1);
    issue(11, 4'hB, 32'h80000000, 32'd4, 32'hF8000000, 0, 0, 0, 0, 1);
    issue(12, 4'hD, 32'h1, 32'd1, 32'h80000000, 0, 0, 0, 0, 1);
    issue(13, 4'hC, 32'h12345678, 32'd0, 32'h12345678, 0, 0, 0, 0, 1);
    issue(14, 4'hE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 0, 0, 0, 0, 1);
    issue(15, 4'd6, 32'h10000, 32'h10000, 32'h0, 32'h1, 0, 0, 0, 33);
    issue(16, 4'd7, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0, 33);
    issue(17, 4'd7, 32'd100, 32'd0, 32'hFFFFFFFF, 32'd100, 0, 0, 1, 1);
    issue(18, 4'd8, 32'd100, 32'd7, 32'd2, 32'd0, 0, 0, 0, 33);
    issue(19, 4'd8, 32'd5, 32'd0, 32'd5, 32'd0, 0, 0, 1, 1);
`ifdef ALU_SIGNED_MULDIV_EN
    issue(20, 4'd6, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 0, 0, 33);
    issue(21, 4'd7, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0, 33);
    issue(22, 4'd7, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 0, 1, 0, 33);
`else
    issue(20, 4'd6, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 32'h1, 0, 0, 0, 33);
    issue(21, 4'd7, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'h1, 0, 0, 0, 33);
    issue(22, 4'd7, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 0, 0, 33);
`endif
    out_ready = 1'b0;
    issue(23, 4'd2, 32'hAAAAAAAA, 32'hFFFF0000, 32'h5555AAAA, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); A = 32'h1; B = 32'h2; opcode = 4'd4;
      @(negedge clock);
      chk("hold_stable", {out_valid, in_ready, result_lo, result_hi, carry_out, overflow, div_by_zero},
          {1'b1, 1'b0, 32'h5555AAAA, 32'h0, 3'b000});
      @(posedge clock); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clock); #1;
    chk("hold_release_idle", {out_valid, in_ready}, 80'b01);
    in_valid = 1'b1; A = 32'hFFFFFFFF; B = 32'd2; opcode = 4'd6;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clock);
    #1 chk("mul_busy", {out_valid, in_ready}, 80'b00);
    clear = 1'b1;
    #1 chk("abort_outputs", {out_valid, in_ready, result_lo, result_hi, carry_out, overflow, div_by_zero}, '0);
    @(posedge clock); #1;
    clear = 1'b0;
    #1 chk("abort_ready", {out_valid, in_ready}, 80'b01);
    issue(24, 4'd4, 32'd2, 32'd3, 32'd5, 0, 0, 0, 0, 1);
    repeat (40) @(posedge clock);
    #1 chk("scoreboard_empty", 80'(sb_q.size()), 80'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
